// File: rtl/comb_wires_4x2b_rr_mux_ctrl.sv
// Round-robin arbiter sharing one nbits-wide output channel among four val/rdy
// requesters, with a single-entry registered output buffer.
module comb_wires_4x2b_rr_mux_ctrl #(
    parameter int nbits = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    input  logic [nbits-1:0] in2,
    input  logic [nbits-1:0] in3,
    input  logic [3:0]       in_val,
    output logic [3:0]       in_rdy,
    output logic [nbits-1:0] out,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [1:0]       out_src
);

    logic [nbits-1:0] out_q, out_d;
    logic [1:0]       src_q, src_d;
    logic             val_q, val_d;
    logic [1:0]       ptr_q, ptr_d;

    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic [1:0]       idx;
    logic [nbits-1:0] gnt_data;
    logic             can_accept;
    logic             xfer;

    // Walk the priority ring backwards so the entry nearest ptr wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (in_val[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        case (gnt_idx)
            2'd0:    gnt_data = in0;
            2'd1:    gnt_data = in1;
            2'd2:    gnt_data = in2;
            default: gnt_data = in3;
        endcase
    end

    // The out_rdy -> in_rdy combinational path lets a draining buffer refill in the same cycle.
    assign can_accept = !val_q || out_rdy;
    assign xfer       = !reset && gnt_vld && can_accept;

    always_comb begin
        in_rdy = 4'b0000;
        if (xfer) begin
            in_rdy[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_d = out_q;
        src_d = src_q;
        val_d = val_q;
        ptr_d = ptr_q;
        if (xfer) begin
            out_d = gnt_data;
            src_d = gnt_idx;
            val_d = 1'b1;
            ptr_d = gnt_idx + 2'd1;
        end else if (val_q && out_rdy) begin
            val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            src_q <= 2'd0;
            val_q <= 1'b0;
            ptr_q <= 2'd0;
        end else begin
            out_q <= out_d;
            src_q <= src_d;
            val_q <= val_d;
            ptr_q <= ptr_d;
        end
    end

    assign out     = out_q;
    assign out_src = src_q;
    assign out_val = val_q;

endmodule

// File: tb/tb_comb_wires_4x2b_rr_mux_ctrl.sv
// Bench for the 4-way round-robin output-channel controller: directed vector
// table followed by randomized traffic checked against a transaction-level model.
module tb_comb_wires_4x2b_rr_mux_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in0, in1, in2, in3;
    logic [3:0] in_val;
    logic [3:0] in_rdy;
    logic [1:0] out;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] out_src;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    comb_wires_4x2b_rr_mux_ctrl #(.nbits(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .out     (out),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_src (out_src)
    );

    typedef struct {
        logic       rst;
        logic [3:0] val;
        logic [7:0] data;   // {in3,in2,in1,in0}
        logic       ordy;
        logic [3:0] e_rdy;
        logic [1:0] e_out;
        logic [1:0] e_src;
        logic       e_val;
    } vec_t;

    vec_t tbl[$];

    // Reference model: buffer contents and rotating priority as plain integers.
    int m_ptr = 0;
    int m_val = 0;
    int m_out = 0;
    int m_src = 0;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [7:0] d, logic o,
                                logic [3:0] er, logic [1:0] eo, logic [1:0] es, logic ev);
        vec_t t;
        t.rst = r; t.val = v; t.data = d; t.ordy = o;
        t.e_rdy = er; t.e_out = eo; t.e_src = es; t.e_val = ev;
        return t;
    endfunction

    function automatic int in_data(int g);
        case (g)
            0:       return int'(in0);
            1:       return int'(in1);
            2:       return int'(in2);
            default: return int'(in3);
        endcase
    endfunction

    function automatic int model_grant();
        if (reset) return -1;
        if (m_val != 0 && !out_rdy) return -1;
        for (int k = 0; k < 4; k++) begin
            if (in_val[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (reset) begin
            m_ptr = 0; m_val = 0; m_out = 0; m_src = 0;
        end else if (g >= 0) begin
            m_out = in_data(g); m_src = g; m_val = 1; m_ptr = (g + 1) % 4;
        end else if (m_val != 0 && out_rdy) begin
            m_val = 0;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic [3:0] v, logic [7:0] d, logic o);
        @(negedge clk);
        reset  = r;
        in_val = v;
        {in3, in2, in1, in0} = d;
        out_rdy = o;
        #1;
    endtask

    initial begin
        int g;
        reset = 1'b1; in_val = 4'h0; {in3, in2, in1, in0} = 8'h00; out_rdy = 1'b0;

        // reset and idle
        tbl.push_back(mk(1, 4'hF, 8'h00, 1, 4'b0000, 2'd0, 2'd0, 0));
        tbl.push_back(mk(1, 4'hF, 8'h00, 1, 4'b0000, 2'd0, 2'd0, 0));
        tbl.push_back(mk(0, 4'h0, 8'h00, 1, 4'b0000, 2'd0, 2'd0, 0));
        // single requester 2, then drain
        tbl.push_back(mk(0, 4'b0100, 8'h30, 1, 4'b0100, 2'd3, 2'd2, 1));
        tbl.push_back(mk(0, 4'b0000, 8'h00, 1, 4'b0000, 2'd3, 2'd2, 0));
        // reset to ptr=0, then full rotation with in_i = i
        tbl.push_back(mk(1, 4'h0, 8'h00, 1, 4'b0000, 2'd0, 2'd0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 4'hF, 8'hE4, 1, 4'(1 << (i % 4)), 2'(i % 4), 2'(i % 4), 1));
        // reset mid-stream
        tbl.push_back(mk(0, 4'hF, 8'hE4, 1, 4'b0001, 2'd0, 2'd0, 1));
        tbl.push_back(mk(1, 4'hF, 8'hE4, 1, 4'b0000, 2'd0, 2'd0, 0));
        tbl.push_back(mk(0, 4'hF, 8'hE4, 1, 4'b0001, 2'd0, 2'd0, 1));
        // buffer out=2 from requester 1 (ptr becomes 2), then backpressure
        tbl.push_back(mk(0, 4'b0010, 8'h08, 1, 4'b0010, 2'd2, 2'd1, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 4'b1001, 8'hC1, 0, 4'b0000, 2'd2, 2'd1, 1));
        tbl.push_back(mk(0, 4'b1001, 8'hC1, 1, 4'b1000, 2'd3, 2'd3, 1));
        // drain, then wrap: ptr=0 after grant to 3; empty buffer accepts with out_rdy=0
        tbl.push_back(mk(0, 4'b0000, 8'h00, 1, 4'b0000, 2'd3, 2'd3, 0));
        tbl.push_back(mk(0, 4'hF, 8'hE4, 0, 4'b0001, 2'd0, 2'd0, 1));
        tbl.push_back(mk(0, 4'hF, 8'hE4, 0, 4'b0000, 2'd0, 2'd0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].val, tbl[i].data, tbl[i].ordy);
            chk($sformatf("vec%0d in_rdy", i), int'(in_rdy), int'(tbl[i].e_rdy));
            model_edge();
            @(posedge clk); #1;
            chk($sformatf("vec%0d out", i), int'(out), int'(tbl[i].e_out));
            chk($sformatf("vec%0d out_src", i), int'(out_src), int'(tbl[i].e_src));
            chk($sformatf("vec%0d out_val", i), int'(out_val), int'(tbl[i].e_val));
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0), 4'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
            g = model_grant();
            chk("rand in_rdy", int'(in_rdy), (g < 0) ? 0 : (1 << g));
            model_edge();
            @(posedge clk); #1;
            chk("rand out_val", int'(out_val), m_val);
            if (m_val != 0) begin
                chk("rand out", int'(out), m_out);
                chk("rand out_src", int'(out_src), m_src);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
